// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, default timing constants and
// the host-transmitter state encoding.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_FILTER_LEN     = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RTS   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    // Data bits plus odd parity on top, shifted out LSB first.
    function automatic logic [PS2_DATA_BITS:0] ps2_frame(input logic [PS2_DATA_BITS-1:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter on the PS/2 clock line with a filtered level and a
// one-cycle falling-edge strobe; shared by the transmitter and receiver.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic f_ps2c,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_reg;
    logic                  f_next;

    // Filter resets to all ones so the line looks idle-high and no
    // spurious falling edge appears when reset is released.
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filter_reg <= '1;
            f_reg      <= 1'b1;
        end else begin
            filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
            f_reg      <= f_next;
        end
    end

    always_comb begin
        f_next = f_reg;
        if (&filter_reg)
            f_next = 1'b1;
        else if (~|filter_reg)
            f_next = 1'b0;
    end

    assign f_ps2c    = f_reg;
    assign fall_edge = f_reg & ~f_next;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out frame,
// device ack capture and an inter-edge watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_ps2,
    input  logic [PS2_DATA_BITS-1:0] din,
    inout  wire                      ps2c,
    inout  wire                      ps2d,
    output logic                     rx_en,
    output logic                     tx_idle,
    output logic                     tx_done_tick,
    output logic                     tx_err
);

    localparam int T_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int T_W   = $clog2(T_MAX);
    localparam logic [T_W-1:0] T_INHIBIT = T_W'(INHIBIT_CYCLES - 1);
    localparam logic [T_W-1:0] T_TIMEOUT = T_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state_reg, state_next;
    logic [T_W-1:0]         t_reg, t_next;
    logic [3:0]             n_reg, n_next;
    logic [PS2_DATA_BITS:0] b_reg, b_next;
    logic                   err_reg, err_next;
    logic                   done_reg, done_next;
    logic                   c_drv, d_drv;
    logic                   f_ps2c, fall_edge;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .f_ps2c    (f_ps2c),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            t_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    // A fall edge always takes priority over watchdog expiry in the same cycle.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned and a latch is never inferred.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        c_drv      = 1'b0;
        d_drv      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (wr_ps2) begin
                    b_next     = ps2_frame(din);
                    t_next     = T_INHIBIT;
                    err_next   = 1'b0;
                    state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                c_drv = 1'b1;
                if (t_reg == '0) begin
                    t_next     = T_TIMEOUT;
                    state_next = ST_START;
                end else begin
                    t_next = t_reg - 1'b1;
                end
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (state_reg == ST_START)
                    d_drv = 1'b1;
                else if (state_reg == ST_DATA)
                    d_drv = ~b_reg[0];

                if (fall_edge) begin
                    t_next = T_TIMEOUT;
                    case (state_reg)
                        ST_START: begin
                            n_next     = 4'd8;
                            state_next = ST_DATA;
                        end
                        ST_DATA: begin
                            b_next = {1'b0, b_reg[PS2_DATA_BITS:1]};
                            if (n_reg == 4'd0)
                                state_next = ST_STOP;
                            else
                                n_next = n_reg - 4'd1;
                        end
                        default: begin
                            err_next   = ps2d;
                            state_next = ST_DRAIN;
                        end
                    endcase
                end else if (t_reg == '0) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    t_next = t_reg - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (f_ps2c && ps2d) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ps2c = c_drv ? 1'b0 : 1'bz;
    assign ps2d = d_drv ? 1'b0 : 1'bz;

    assign rx_en        = (state_reg == ST_IDLE);
    assign tx_idle      = (state_reg == ST_IDLE);
    assign tx_done_tick = done_reg;
    assign tx_err       = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: pulled-up bus, a behavioural keyboard that clocks
// frames in and acks, plus abort, ignore and mid-frame reset scenarios.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 400;
    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       rx_en, tx_idle, tx_done_tick, tx_err;
    logic       dev_c, dev_d;
    wire        ps2c, ps2d;

    int tests      = 0;
    int fails      = 0;
    int done_count = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (tx_done_tick === 1'b1)
            done_count <= done_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line order as seen on the wire: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        wr_ps2 = 1'b1;
        din    = d;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("rx_en_falls", rx_en, 1'b0);
        check("tx_idle_falls", tx_idle, 1'b0);
        check("ps2c_low_next_cycle", ps2c, 1'b0);
        check("tx_err_cleared", tx_err, 1'b0);
    endtask

    // Keyboard model: times the inhibit, then generates n_edges clock pulses,
    // sampling the line on each rising edge and driving ack around edge 11.
    task automatic device_frame(input int n_edges, input bit ack, input bit poke,
                                output logic [10:0] frame, output int low_cycles);
        int cnt;
        frame = '1;
        cnt   = 0;
        while (ps2c === 1'b0 && cnt < 10000) begin
            cnt++;
            @(negedge clk);
        end
        low_cycles = cnt;
        frame[0]   = ps2d;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && ack)
                dev_d = 1'b1;
            dev_c = 1'b1;
            for (int j = 0; j < HALF; j++) begin
                @(negedge clk);
                if (poke && i == 3 && j == 10) begin
                    wr_ps2 = 1'b1;
                    din    = 8'h55;
                end else begin
                    wr_ps2 = 1'b0;
                end
            end
            dev_c = 1'b0;
            if (i <= 10)
                frame[i] = ps2d;
            repeat (HALF) @(negedge clk);
            if (i == 11)
                dev_d = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit poke, input string tag);
        logic [10:0] fr;
        int          low;
        int          prev;
        int          cnt;
        prev = done_count;
        start_tx(d);
        device_frame(11, ack, poke, fr, low);
        check($sformatf("%s_inhibit", tag), low, INH);
        check($sformatf("%s_frame", tag), fr, model_frame(d));
        cnt = 0;
        while (done_count == prev && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check($sformatf("%s_done_once", tag), done_count - prev, 1);
        check($sformatf("%s_tx_err", tag), tx_err, !ack);
        check($sformatf("%s_tx_idle", tag), tx_idle, 1'b1);
        check($sformatf("%s_rx_en", tag), rx_en, 1'b1);
    endtask

    initial begin
        logic [10:0] fr;
        logic [10:0] exp_fr;
        logic [7:0]  d;
        int          low;
        int          prev;
        int          k;

        reset  = 1'b0;
        wr_ps2 = 1'b0;
        din    = 8'h00;
        dev_c  = 1'b0;
        dev_d  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_en", rx_en, 1'b1);
        check("rst_tx_idle", tx_idle, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_tx_err", tx_err, 1'b0);
        check("rst_ps2c_released", ps2c, 1'b1);
        check("rst_ps2d_released", ps2d, 1'b1);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", tx_idle, 1'b1);
        check("post_rst_no_tick", done_count, 0);

        run_frame(8'hED, 1'b1, 1'b0, "led_cmd");
        run_frame(8'h00, 1'b1, 1'b0, "zero");
        run_frame(8'hFF, 1'b1, 1'b0, "ones");
        run_frame(8'h01, 1'b1, 1'b0, "one_bit");
        run_frame(8'($urandom), 1'b0, 1'b0, "no_ack");

        // Device never clocks: watchdog fires TO cycles after START entry.
        prev = done_count;
        start_tx(8'hA5);
        k = 0;
        while (tx_done_tick !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, INH + TO);
        check("timeout_ps2c", ps2c, 1'b1);
        check("timeout_ps2d", ps2d, 1'b1);
        check("timeout_tx_err", tx_err, 1'b1);
        check("timeout_tx_idle", tx_idle, 1'b1);
        repeat (3) @(negedge clk);
        check("timeout_done_once", done_count - prev, 1);

        run_frame(8'hED, 1'b1, 1'b1, "wr_ignored");

        for (int r = 0; r < 4; r++)
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));

        // Mid-frame reset while the host is holding a 0 data bit on ps2d.
        d      = 8'($urandom) & 8'hF7;
        exp_fr = model_frame(d);
        prev   = done_count;
        start_tx(d);
        device_frame(4, 1'b0, 1'b0, fr, low);
        check("midrst_inhibit", low, INH);
        check("midrst_partial_frame", fr[4:0], exp_fr[4:0]);
        check("midrst_d3_driven", ps2d, 1'b0);
        check("midrst_rx_en_busy", rx_en, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_ps2c_released", ps2c, 1'b1);
        check("midrst_ps2d_released", ps2d, 1'b1);
        check("midrst_rx_en", rx_en, 1'b1);
        check("midrst_tx_idle", tx_idle, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_tick", done_count - prev, 0);

        run_frame(8'hFF, 1'b1, 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
